// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin packet arbiter:
// FSM state encoding and the grant-index width helper.
package rr_arb_pkg;

  // FSM state encoding (kept as plain constants for legacy tools)
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Width of a binary requester index; a single requester still gets one bit
  function automatic int idw(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Rotating priority picker.
// The request vector is rotated so that requester 'ptr' lands on bit 0.
// The lowest set bit of the rotated vector wins, exactly as in the old
// fixed-priority arbiter. The winning position is then mapped back to the
// real requester index.
// Purely combinational.
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   win,
  output logic [IDW-1:0] win_id,
  output logic           valid
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  int             sel_s;
  int             sum_s;

  // Rotate, priority-encode the lowest set bit, then unrotate to a real index
  always_comb begin
    dbl_s = {req, req};
    rot_s = dbl_s[int'(ptr) +: N];
    sel_s = 32'sd0;
    for (int k = N - 1; k >= 0; k--) begin
      sel_s = rot_s[k] ? k : sel_s;
    end
    sum_s = int'(ptr) + sel_s;
    if (sum_s >= N) begin
      sum_s = sum_s - N;
    end else begin
      sum_s = sum_s;
    end
    valid  = |req;
    win_id = valid ? IDW'(sum_s) : '0;
    win    = valid ? (N'(1) << sum_s) : '0;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin packet arbiter.
// N requesters share one downstream channel. The grant is registered and
// held for a whole packet; it is released on an accepted beat carrying
// 'last'. On release the arbiter re-arbitrates in the same cycle, so
// back-to-back packets see no bubble. The pointer advances to winner+1 at
// every new grant, which makes the previous winner the lowest priority.
//
// Optional feature: define RR_ARB_MAXBURST_EN to cap every grant at
// MAXBURST beats. The MAXBURST-th beat then releases the grant just as
// 'last' does. Without the macro, MAXBURST is ignored.
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAXBURST = 8,
  localparam int IDW     = idw(N)
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   last,
  input  logic           ready,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy
);

  logic [0:0]     state_r;
  logic [0:0]     state_n_s;
  logic [IDW-1:0] ptr_r;
  logic [IDW-1:0] ptr_n_s;
  logic [N-1:0]   grant_r;
  logic [N-1:0]   grant_n_s;
  logic [IDW-1:0] id_r;
  logic [IDW-1:0] id_n_s;
  logic           busy_r;

  logic [N-1:0]   win_s;
  logic [IDW-1:0] win_id_s;
  logic           win_vld_s;
  logic [IDW-1:0] ptr_adv_s;
  int             ptr_sum_s;

  logic           beat_s;
  logic           burst_end_s;
  logic           rel_s;
  logic           new_grant_s;

  rr_arb_pick #(
    .N (N)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_r),
    .win    (win_s),
    .win_id (win_id_s),
    .valid  (win_vld_s)
  );

  // Pointer value that follows a grant to win_id_s: (winner + 1) mod N
  always_comb begin
    ptr_sum_s = int'(win_id_s) + 1;
    if (ptr_sum_s >= N) begin
      ptr_sum_s = 0;
    end else begin
      ptr_sum_s = ptr_sum_s;
    end
    ptr_adv_s = IDW'(ptr_sum_s);
  end

  // A beat is an accepted transfer from the current owner while a grant is active
  always_comb begin
    if (state_r == ST_BUSY) begin
      beat_s = req[id_r] & grant_r[id_r] & ready;
    end else begin
      beat_s = 1'b0;
    end
  end

`ifdef RR_ARB_MAXBURST_EN
  localparam int CW = $clog2(MAXBURST + 1);

  logic [CW-1:0] cnt_r;

  // The beat that completes MAXBURST beats ends the grant
  always_comb begin
    if (cnt_r == CW'(MAXBURST - 1)) begin
      burst_end_s = beat_s;
    end else begin
      burst_end_s = 1'b0;
    end
  end

  // Beats taken under the current grant; a new grant restarts the count
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_r <= '0;
    end else if (new_grant_s) begin
      cnt_r <= '0;
    end else if (beat_s) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  // Only 'last' ends a grant in this build
  always_comb begin
    burst_end_s = 1'b0;
  end
`endif

  // Release on the final beat of a packet (or of a capped burst)
  always_comb begin
    rel_s = beat_s & (last[id_r] | burst_end_s);
  end

  // Next-state logic: grant from IDLE, hold while BUSY, re-arbitrate on release
  always_comb begin
    state_n_s   = state_r;
    ptr_n_s     = ptr_r;
    grant_n_s   = grant_r;
    id_n_s      = id_r;
    new_grant_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_vld_s) begin
          state_n_s   = ST_BUSY;
          grant_n_s   = win_s;
          id_n_s      = win_id_s;
          ptr_n_s     = ptr_adv_s;
          new_grant_s = 1'b1;
        end else begin
          grant_n_s = '0;
          id_n_s    = '0;
        end
      end
      ST_BUSY: begin
        if (rel_s) begin
          if (win_vld_s) begin
            state_n_s   = ST_BUSY;
            grant_n_s   = win_s;
            id_n_s      = win_id_s;
            ptr_n_s     = ptr_adv_s;
            new_grant_s = 1'b1;
          end else begin
            state_n_s = ST_IDLE;
            grant_n_s = '0;
            id_n_s    = '0;
          end
        end else begin
          state_n_s = ST_BUSY;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        grant_n_s = '0;
        id_n_s    = '0;
      end
    endcase
  end

  // State, pointer and registered grant outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      grant_r <= '0;
      id_r    <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      ptr_r   <= ptr_n_s;
      grant_r <= grant_n_s;
      id_r    <= id_n_s;
      busy_r  <= |grant_n_s;
    end
  end

  assign grant    = grant_r;
  assign grant_id = id_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (N=4, MAXBURST=2).
// A behavioural model tracks the owner and the previous winner. Directed
// sequences are checked against constants, and random packet traffic is
// checked against the model on every cycle.
module tb_rr_arbiter;

  localparam int N   = 4;
  localparam int MB  = 2;
  localparam int IDW = 2;
`ifdef RR_ARB_MAXBURST_EN
  localparam bit MB_EN = 1'b1;
`else
  localparam bit MB_EN = 1'b0;
`endif

  logic           clk;
  logic           nreset;
  logic [N-1:0]   req;
  logic [N-1:0]   last;
  logic           ready;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;

  int total;
  int bad;

  // model state: owner (-1 = none), previous winner, beats in grant
  int owner;
  int prev;
  int cnt;
  int beat_id;
  int remaining [N];

  rr_arbiter #(
    .N        (N),
    .MAXBURST (MB)
  ) dut (
    .clk      (clk),
    .nreset   (nreset),
    .req      (req),
    .last     (last),
    .ready    (ready),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_m(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1;
    prev  = N - 1;
    cnt   = 0;
    for (int i = 0; i < N; i++) remaining[i] = 0;
  endtask

  task automatic model_clock();
    int w;
    beat_id = -1;
    if (!nreset) begin
      model_reset();
    end else if (owner < 0) begin
      w = pick_m(req, prev);
      if (w >= 0) begin
        owner = w; prev = w; cnt = 0;
      end
    end else if (req[owner] && ready) begin
      beat_id = owner;
      cnt++;
      if (last[owner] || (MB_EN && cnt == MB)) begin
        w = pick_m(req, prev);
        owner = w;
        cnt = 0;
        if (w >= 0) prev = w;
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] eg;
    eg = (owner < 0) ? 32'd0 : (32'd1 << owner);
    chk("grant", {28'd0, grant}, eg);
    chk("grant_id", {30'd0, grant_id}, (owner < 0) ? 32'd0 : owner);
    chk("busy", {31'd0, busy}, (owner >= 0) ? 32'd1 : 32'd0);
    chk("onehot0", {31'd0, $onehot0(grant)}, 32'd1);
    if (grant != 4'd0) chk("id_match", {31'd0, grant[grant_id]}, 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic vec(input string tag, input logic [3:0] r, input logic [3:0] l,
                     input logic rd, input logic [3:0] exp);
    req = r; last = l; ready = rd;
    step();
    chk(tag, {28'd0, grant}, {28'd0, exp});
  endtask

  // assert reset at a negedge, check it takes effect at once, release after one edge
  task automatic pulse_reset();
    nreset = 1'b0;
    #1;
    model_reset();
    chk("rst_now", {28'd0, grant}, 32'd0);
    check_outputs();
    step();
    nreset = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0;
    model_reset();
    beat_id = -1;
    req = 4'b0000; last = 4'b0000; ready = 1'b0;
    nreset = 1'b0;
    @(negedge clk);

    // 1: reset held with all requesting
    req = 4'b1111; last = 4'b1111; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_grant", {28'd0, grant}, 32'd0);
      chk("t1_id", {30'd0, grant_id}, 32'd0);
      chk("t1_busy", {31'd0, busy}, 32'd0);
    end
    nreset = 1'b1;

    // 2: full rotation with single-beat packets, no bubble
    vec("t2_0", 4'b1111, 4'b1111, 1'b1, 4'b0001);
    vec("t2_1", 4'b1111, 4'b1111, 1'b1, 4'b0010);
    vec("t2_2", 4'b1111, 4'b1111, 1'b1, 4'b0100);
    vec("t2_3", 4'b1111, 4'b1111, 1'b1, 4'b1000);
    vec("t2_4", 4'b1111, 4'b1111, 1'b1, 4'b0001);
    pulse_reset();

    // 3: two requesters alternate, others never granted
    vec("t3_0", 4'b0101, 4'b0101, 1'b1, 4'b0001);
    vec("t3_1", 4'b0101, 4'b0101, 1'b1, 4'b0100);
    vec("t3_2", 4'b0101, 4'b0101, 1'b1, 4'b0001);
    vec("t3_3", 4'b0101, 4'b0101, 1'b1, 4'b0100);
    pulse_reset();

`ifndef RR_ARB_MAXBURST_EN
    // 4: four-beat packet with one stall, waiting requester follows without a bubble
    vec("t4_g", 4'b0100, 4'b0000, 1'b1, 4'b0100);
    vec("t4_b1", 4'b0101, 4'b0000, 1'b1, 4'b0100);
    vec("t4_st", 4'b0101, 4'b0000, 1'b0, 4'b0100);
    vec("t4_b2", 4'b0101, 4'b0000, 1'b1, 4'b0100);
    vec("t4_b3", 4'b0101, 4'b0000, 1'b1, 4'b0100);
    vec("t4_b4", 4'b0101, 4'b0100, 1'b1, 4'b0001);
    pulse_reset();
`else
    // 5: burst cap forces release without last
    vec("t5_g", 4'b0010, 4'b0000, 1'b1, 4'b0010);
    vec("t5_b1", 4'b1010, 4'b0000, 1'b1, 4'b0010);
    vec("t5_b2", 4'b1010, 4'b0000, 1'b1, 4'b1000);
    vec("t5_b3", 4'b1010, 4'b1000, 1'b1, 4'b0010);
    pulse_reset();
`endif

    // 6: reset mid-packet, then a fresh round starts at requester 0
    vec("t6_g", 4'b0010, 4'b0000, 1'b1, 4'b0010);
    vec("t6_b", 4'b0010, 4'b0000, 1'b1, 4'b0010);
    pulse_reset();
    vec("t6_after", 4'b1111, 4'b1111, 1'b1, 4'b0001);
    pulse_reset();

    // random protocol-compliant packet traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        pulse_reset();
      end else begin
        for (int i = 0; i < N; i++) begin
          if (remaining[i] == 0 && $urandom_range(0, 3) == 0)
            remaining[i] = $urandom_range(1, 5);
          req[i]  = (remaining[i] > 0);
          last[i] = (remaining[i] == 1);
        end
        ready = ($urandom_range(0, 3) != 0);
        step();
        if (beat_id >= 0) remaining[beat_id]--;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
